// File: rtl/fp_wb_arbiter.sv
// Round-robin arbiter sharing the FP register-file writeback port across FP units.
// Optional sticky fflags accumulator enabled by defining FP_WB_FFLAGS_ACCUM_EN.
module fp_wb_arbiter #(
   parameter int unsigned NUM_UNITS  = 5,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ID_WIDTH   = 3,
   parameter int unsigned FLAG_WIDTH = 5
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_UNITS-1:0]             unit_done,
   input  logic [NUM_UNITS*ID_WIDTH-1:0]    unit_id,
   input  logic [NUM_UNITS*DATA_WIDTH-1:0]  unit_rd,
   input  logic [NUM_UNITS*FLAG_WIDTH-1:0]  unit_fflags,
   output logic [NUM_UNITS-1:0]             unit_ack,
   output logic                             wb_valid,
   output logic [ID_WIDTH-1:0]              wb_id,
   output logic [DATA_WIDTH-1:0]            wb_rd,
   output logic [FLAG_WIDTH-1:0]            wb_fflags,
   output logic [NUM_UNITS-1:0]             wb_unit,
`ifdef FP_WB_FFLAGS_ACCUM_EN
   output logic [FLAG_WIDTH-1:0]            fflags_acc,
   input  logic                             fflags_clr,
`endif
   input  logic                             wb_ack
);

   localparam int unsigned PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

   slot_t            state;
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] cand;
   logic [PTR_W-1:0] grant_idx;
   logic [PTR_W-1:0] next_ptr;
   logic             grant_found;
   logic             can_load;
   logic             grant;

   assign wb_valid = (state == FULL);
   assign can_load = ~wb_valid | wb_ack;
   assign grant    = |unit_ack;
   assign next_ptr = (grant_idx == PTR_W'(NUM_UNITS - 1)) ? '0 : grant_idx + PTR_W'(1);

   // First requester at or above rr_ptr, wrapping modulo NUM_UNITS
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      unit_ack    = '0;
      for (int unsigned k = 0; k < NUM_UNITS; k++) begin
         cand = PTR_W'((32'(rr_ptr) + k) % NUM_UNITS);
         if (!grant_found && unit_done[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
      if (!rst && can_load && grant_found)
         unit_ack[grant_idx] = 1'b1;
   end

   // Writeback slot: load on grant, release on ack, data held when released
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= EMPTY;
         wb_id     <= '0;
         wb_rd     <= '0;
         wb_fflags <= '0;
         wb_unit   <= '0;
         rr_ptr    <= '0;
      end else if (grant) begin
         state     <= FULL;
         wb_id     <= unit_id[grant_idx*ID_WIDTH +: ID_WIDTH];
         wb_rd     <= unit_rd[grant_idx*DATA_WIDTH +: DATA_WIDTH];
         wb_fflags <= unit_fflags[grant_idx*FLAG_WIDTH +: FLAG_WIDTH];
         wb_unit   <= unit_ack;
         rr_ptr    <= next_ptr;
      end else if (wb_ack) begin
         state     <= EMPTY;
      end
   end

`ifdef FP_WB_FFLAGS_ACCUM_EN
   logic accept;
   assign accept = wb_valid & wb_ack;

   // Sticky OR of accepted flags; a clear coinciding with an accept keeps only the new flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         fflags_acc <= '0;
      else if (fflags_clr)
         fflags_acc <= accept ? wb_fflags : '0;
      else if (accept)
         fflags_acc <= fflags_acc | wb_fflags;
   end
`endif

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Directed testbench for fp_wb_arbiter: grant order, backpressure, wrap and async reset.
module tb_fp_wb_arbiter;

   localparam int unsigned N  = 5;
   localparam int unsigned DW = 64;
   localparam int unsigned IW = 3;
   localparam int unsigned FW = 5;

   logic              clk;
   logic              rst;
   logic [N-1:0]      unit_done;
   logic [N*IW-1:0]   unit_id;
   logic [N*DW-1:0]   unit_rd;
   logic [N*FW-1:0]   unit_fflags;
   logic [N-1:0]      unit_ack;
   logic              wb_valid;
   logic [IW-1:0]     wb_id;
   logic [DW-1:0]     wb_rd;
   logic [FW-1:0]     wb_fflags;
   logic [N-1:0]      wb_unit;
   logic              wb_ack;
`ifdef FP_WB_FFLAGS_ACCUM_EN
   logic [FW-1:0]     fflags_acc;
   logic              fflags_clr;
`endif

   int tests = 0;
   int fails = 0;

   fp_wb_arbiter #(
      .NUM_UNITS(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .FLAG_WIDTH(FW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .unit_done(unit_done),
      .unit_id(unit_id),
      .unit_rd(unit_rd),
      .unit_fflags(unit_fflags),
      .unit_ack(unit_ack),
      .wb_valid(wb_valid),
      .wb_id(wb_id),
      .wb_rd(wb_rd),
      .wb_fflags(wb_fflags),
      .wb_unit(wb_unit),
`ifdef FP_WB_FFLAGS_ACCUM_EN
      .fflags_acc(fflags_acc),
      .fflags_clr(fflags_clr),
`endif
      .wb_ack(wb_ack)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_unit(input int i, input logic done, input logic [IW-1:0] id,
                           input logic [DW-1:0] rd, input logic [FW-1:0] ff);
      unit_done[i]         = done;
      unit_id[i*IW +: IW]  = id;
      unit_rd[i*DW +: DW]  = rd;
      unit_fflags[i*FW +: FW] = ff;
   endtask

   // Short reset pulse placed between clock edges
   task automatic pulse_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      wb_ack = 1'b0;
      unit_done = '1;
      unit_id = '0;
      unit_rd = '0;
      unit_fflags = '0;
`ifdef FP_WB_FFLAGS_ACCUM_EN
      fflags_clr = 1'b0;
`endif
      tick();
      tick();
      // Reset state, with requests present
      chk("rst_valid", 64'(wb_valid), 64'd0);
      chk("rst_id", 64'(wb_id), 64'd0);
      chk("rst_rd", wb_rd, 64'd0);
      chk("rst_fflags", 64'(wb_fflags), 64'd0);
      chk("rst_unit", 64'(wb_unit), 64'd0);
      chk("rst_ack", 64'(unit_ack), 64'd0);
      unit_done = '0;
      rst = 1'b0;
      tick();

      // Single request from unit 2
      set_unit(2, 1'b1, 3'd5, 64'h3FF0000000000000, 5'h01);
      wb_ack = 1'b1;
      #1;
      chk("single_ack", 64'(unit_ack), 64'b00100);
      chk("single_valid_c0", 64'(wb_valid), 64'd0);
      tick();
      unit_done = '0;
      #1;
      chk("single_valid_c1", 64'(wb_valid), 64'd1);
      chk("single_id", 64'(wb_id), 64'd5);
      chk("single_rd", wb_rd, 64'h3FF0000000000000);
      chk("single_fflags", 64'(wb_fflags), 64'h01);
      chk("single_unit", 64'(wb_unit), 64'b00100);
      chk("single_ack_c1", 64'(unit_ack), 64'd0);
      tick();
      chk("single_valid_c2", 64'(wb_valid), 64'd0);
      chk("single_id_held", 64'(wb_id), 64'd5);
      // wb_ack on an empty slot is ignored
      tick();
      chk("empty_ack_ignored", 64'(wb_valid), 64'd0);

      // Round-robin saturation from rr_ptr 0
      pulse_reset();
      tick();
      for (int i = 0; i < 5; i++)
         set_unit(i, 1'b1, IW'(i), 64'h1000 + 64'(i), FW'(i + 1));
      wb_ack = 1'b1;
      #1;
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("rr_ack_%0d", k), 64'(unit_ack), 64'(1) << (k % 5));
         if (k > 0) begin
            chk($sformatf("rr_valid_%0d", k), 64'(wb_valid), 64'd1);
            chk($sformatf("rr_unit_%0d", k), 64'(wb_unit), 64'(1) << ((k - 1) % 5));
            chk($sformatf("rr_rd_%0d", k), wb_rd, 64'h1000 + 64'((k - 1) % 5));
         end
         tick();
      end
      unit_done = '0;
      #1;
      chk("rr_last_unit", 64'(wb_unit), 64'b00001);
      chk("rr_last_valid", 64'(wb_valid), 64'd1);
      tick();

      // Backpressure: unit 1 held in slot while unit 3 waits
      pulse_reset();
      tick();
      wb_ack = 1'b0;
      set_unit(1, 1'b1, 3'd1, 64'h11, 5'h02);
      #1;
      chk("bp_ack1", 64'(unit_ack), 64'b00010);
      tick();
      unit_done[1] = 1'b0;
      set_unit(3, 1'b1, 3'd3, 64'h33, 5'h04);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("bp_stall_ack_%0d", k), 64'(unit_ack), 64'd0);
         chk($sformatf("bp_stall_id_%0d", k), 64'(wb_id), 64'd1);
         chk($sformatf("bp_stall_unit_%0d", k), 64'(wb_unit), 64'b00010);
         chk($sformatf("bp_stall_valid_%0d", k), 64'(wb_valid), 64'd1);
         tick();
      end
      wb_ack = 1'b1;
      #1;
      chk("bp_ack3", 64'(unit_ack), 64'b01000);
      tick();
      unit_done[3] = 1'b0;
      wb_ack = 1'b0;
      #1;
      chk("bp_id3", 64'(wb_id), 64'd3);
      chk("bp_rd3", wb_rd, 64'h33);
      chk("bp_ff3", 64'(wb_fflags), 64'h04);
      chk("bp_unit3", 64'(wb_unit), 64'b01000);

      // Wrap: rr_ptr is 4 after unit 3, so unit 4 beats unit 0
      set_unit(0, 1'b1, 3'd0, 64'hA0, 5'h00);
      set_unit(4, 1'b1, 3'd4, 64'hA4, 5'h10);
      wb_ack = 1'b1;
      #1;
      chk("wrap_ack4", 64'(unit_ack), 64'b10000);
      tick();
      unit_done[4] = 1'b0;
      #1;
      chk("wrap_unit4", 64'(wb_unit), 64'b10000);
      chk("wrap_ack0", 64'(unit_ack), 64'b00001);
      tick();
      unit_done[0] = 1'b0;
      #1;
      chk("wrap_unit0", 64'(wb_unit), 64'b00001);
      chk("wrap_rd0", wb_rd, 64'hA0);
      tick();

      // Async reset with a full slot; rr_ptr 3 beforehand, 0 afterwards
      wb_ack = 1'b0;
      set_unit(2, 1'b1, 3'd2, 64'h22, 5'h00);
      tick();
      unit_done[2] = 1'b0;
      #1;
      chk("ar_full", 64'(wb_valid), 64'd1);
      rst = 1'b1;
      #1;
      chk("ar_valid", 64'(wb_valid), 64'd0);
      chk("ar_unit", 64'(wb_unit), 64'd0);
      set_unit(1, 1'b1, 3'd1, 64'h11, 5'h00);
      set_unit(3, 1'b1, 3'd3, 64'h33, 5'h00);
      #1;
      chk("ar_ack_in_rst", 64'(unit_ack), 64'd0);
      rst = 1'b0;
      #1;
      chk("ar_ack_after", 64'(unit_ack), 64'b00010);
      unit_done = '0;
      tick();

`ifdef FP_WB_FFLAGS_ACCUM_EN
      pulse_reset();
      tick();
      wb_ack = 1'b1;
      set_unit(0, 1'b1, 3'd0, 64'h0, 5'h01);
      tick();
      unit_done[0] = 1'b0;
      set_unit(1, 1'b1, 3'd1, 64'h0, 5'h10);
      #1;
      chk("acc_init", 64'(fflags_acc), 64'h00);
      tick();
      unit_done[1] = 1'b0;
      #1;
      chk("acc_first", 64'(fflags_acc), 64'h01);
      tick();
      chk("acc_both", 64'(fflags_acc), 64'h11);
      fflags_clr = 1'b1;
      tick();
      fflags_clr = 1'b0;
      chk("acc_clr", 64'(fflags_acc), 64'h00);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fp_wb_arbiter.md
Name: fp_wb_arbiter

Overview:
- Shares the single FP register-file writeback port between the FP execution units fed by the FP issue/preprocessing stage: FMA/add, div, sqrt, wb2fp and wb2int.
- Each unit presents a completed result with a done/ack handshake.
- The arbiter grants one unit per cycle, round-robin, into a one-entry registered writeback slot.
- The slot holds until the writeback consumer accepts it, so units stall rather than drop results.

Parameters:
- NUM_UNITS, 5, number of requesting FP units (1..8)
- DATA_WIDTH, 64, result width (double-precision FLEN)
- ID_WIDTH, 3, instruction id width (matches id_t)
- FLAG_WIDTH, 5, fflags width (NV DZ OF UF NX)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- unit_done  in  NUM_UNITS  unit i holds a valid result
- unit_id  in  NUM_UNITS*ID_WIDTH  per-unit id, unit i at [i*ID_WIDTH +: ID_WIDTH]
- unit_rd  in  NUM_UNITS*DATA_WIDTH  per-unit result data
- unit_fflags  in  NUM_UNITS*FLAG_WIDTH  per-unit exception flags
- unit_ack  out  NUM_UNITS  one-hot; unit i's result captured this cycle
- wb_valid  out  1  writeback slot occupied
- wb_id  out  ID_WIDTH  id of slot result
- wb_rd  out  DATA_WIDTH  slot result data
- wb_fflags  out  FLAG_WIDTH  slot flags
- wb_unit  out  NUM_UNITS  one-hot source unit of slot result
- wb_ack  in  1  consumer accepts slot this cycle (only meaningful when wb_valid)

Behaviour:
- Reset (async, rst=1): wb_valid=0, wb_id=0, wb_rd=0, wb_fflags=0, wb_unit=0, rr_ptr=0. unit_ack is combinational and is 0 while rst is high.
- Slot states: EMPTY (wb_valid=0) and FULL (wb_valid=1).
- can_load = ~wb_valid | wb_ack.
- Grant: when can_load and |unit_done, pick the first unit with unit_done set, searching upward from rr_ptr modulo NUM_UNITS. Assert unit_ack for that unit only.
- Capture: on the clock edge after a grant, load the granted unit's id/rd/fflags into the slot and set wb_unit to the grant. wb_valid=1.
- Release: wb_ack with no new grant clears wb_valid the next cycle. Slot data is held, not cleared.
- Simultaneous wb_ack and grant: the slot is overwritten back-to-back and wb_valid stays 1. This gives sustained throughput of 1 result per cycle.
- rr_ptr <= (granted index + 1) mod NUM_UNITS on every grant. Unchanged when there is no grant. Wrap from NUM_UNITS-1 to 0.
- FULL with no wb_ack: unit_ack=0 for all units. Slot contents remain stable (no bubbles, no overwrite).
- Units keep unit_done and their data stable until acked. The arbiter does not latch requests.
- Latency: done to wb_valid is 1 cycle when the slot is empty or being acked.
- wb_ack while wb_valid=0 is ignored.
- Reset mid-operation: the slot is discarded immediately. Units re-present after reset.
- Fairness: under saturation, any continuously requesting unit is granted within NUM_UNITS grants.

Optional Feature:
- Macro: FP_WB_FFLAGS_ACCUM_EN.
- When defined, add ports:
  - fflags_acc  out  FLAG_WIDTH
  - fflags_clr  in  1
- fflags_acc is a sticky OR of wb_fflags over every accepted slot (wb_valid & wb_ack).
- It resets to 0 asynchronously.
- fflags_clr clears it to 0 on the next edge.
- Simultaneous clr and accept loads exactly the accepted flags.
- When undefined: the ports and register are absent and behaviour is otherwise identical.

Test Plan:
- Single request: unit 2 done, id=5, rd=0x3FF0000000000000, fflags=0x01, wb_ack tied 1 -> unit_ack=00100 in cycle 0; cycle 1 wb_valid=1, wb_id=5, wb_rd=0x3FF0000000000000, wb_fflags=0x01, wb_unit=00100; cycle 2 wb_valid=0.
- Round-robin saturation: all 5 units done continuously, wb_ack=1 -> grant order 0,1,2,3,4,0; wb_valid held 1 every cycle after the first.
- Backpressure: unit 1 captured, wb_ack=0 for 3 cycles while unit 3 is done -> unit_ack=0 and slot unchanged for 3 cycles; on the wb_ack cycle unit_ack=01000; unit 3 data appears next cycle.
- Wrap: rr_ptr=4 after granting unit 3, then units 0 and 4 request -> unit 4 granted first, then unit 0.
- Async reset: assert rst mid-cycle with wb_valid=1 -> wb_valid=0 without a clock edge; rr_ptr=0, so with units 1 and 3 requesting after release, unit 1 is granted.
- With FP_WB_FFLAGS_ACCUM_EN: accept flags 0x01 then 0x10 -> fflags_acc=0x11; pulse fflags_clr -> 0x00.
